// File: rtl/jesd204b_pkg.sv
// Shared JESD204B definitions: link state encoding and control-character codes.
package jesd204b_pkg;

  localparam logic [2:0] STATE_WAIT_SYSREF = 3'd0;
  localparam logic [2:0] STATE_CGS         = 3'd1;
  localparam logic [2:0] STATE_SYNC_REL    = 3'd2;
  localparam logic [2:0] STATE_ILAS        = 3'd3;
  localparam logic [2:0] STATE_DATA        = 3'd4;

  typedef enum logic [2:0] {
    StWaitSysref = STATE_WAIT_SYSREF,
    StCgs        = STATE_CGS,
    StSyncRel    = STATE_SYNC_REL,
    StIlas       = STATE_ILAS,
    StData       = STATE_DATA
  } link_state_e;

  // 8b/10b control characters, shared with the lane decoder
  localparam logic [7:0] K28_5_CODE = 8'hBC;  // /K/ comma
  localparam logic [7:0] K28_0_R    = 8'h1C;  // /R/ ILAS start
  localparam logic [7:0] K28_3_A    = 8'h7C;  // /A/ multiframe end

  localparam int unsigned ERR_CNT_MAX = 255;

endpackage

// File: rtl/jesd204b_lmfc_edge_det.sv
// LMFC rising-edge detector plus the RBD delay counter that times buffer release.
module jesd204b_lmfc_edge_det #(
  parameter int unsigned RBD_DLY = 0
) (
  input  logic dclk,
  input  logic rst,
  input  logic i_lmfc,
  input  logic i_arm,      // release is armed; next edge starts the delay
  input  logic i_clear,    // abort any pending release
  output logic o_edge,
  output logic o_release   // one-cycle strobe, registered by the caller
);

  localparam int unsigned RbdW = (RBD_DLY > 0) ? $clog2(RBD_DLY + 1) : 1;
  localparam logic [RbdW-1:0] RbdMax = RbdW'(RBD_DLY);
  localparam logic [RbdW-1:0] RbdOne = RbdW'(1);

  logic            lmfc_q;
  logic            running_q, running_d;
  logic [RbdW-1:0] rbd_cnt_q, rbd_cnt_d;
  logic            start;

  assign o_edge = i_lmfc & ~lmfc_q;
  assign start  = i_arm & o_edge;

  // Delay countdown; strobe fires RBD_DLY cycles after the starting edge cycle
  always_comb begin
    running_d = running_q;
    rbd_cnt_d = rbd_cnt_q;
    o_release = 1'b0;
    if (i_clear) begin
      running_d = 1'b0;
      rbd_cnt_d = '0;
    end else if (running_q) begin
      if (rbd_cnt_q == RbdOne) begin
        o_release = 1'b1;
        running_d = 1'b0;
        rbd_cnt_d = '0;
      end else begin
        rbd_cnt_d = rbd_cnt_q - RbdOne;
      end
    end else if (start) begin
      if (RBD_DLY == 0) begin
        o_release = 1'b1;
      end else begin
        running_d = 1'b1;
        rbd_cnt_d = RbdMax;
      end
    end
  end

  // Edge history and delay counter state
  always_ff @(posedge dclk or posedge rst) begin
    if (rst) begin
      lmfc_q    <= 1'b0;
      running_q <= 1'b0;
      rbd_cnt_q <= '0;
    end else begin
      lmfc_q    <= i_lmfc;
      running_q <= running_d;
      rbd_cnt_q <= rbd_cnt_d;
    end
  end

endmodule

// File: rtl/jesd204b_rx_link_ctrl.sv
// JESD204B receive link controller: CGS -> ILAS -> DATA sequencing, SYNC~ drive
// and deterministic elastic-buffer release on an LMFC boundary.
module jesd204b_rx_link_ctrl
  import jesd204b_pkg::*;
#(
  parameter int unsigned CGS_K_CNT    = 4,
  parameter int unsigned ILAS_MF      = 4,
  parameter int unsigned ILAS_TIMEOUT = 8,
  parameter int unsigned RBD_DLY      = 0,
  parameter int unsigned ERR_THRESH   = 3
) (
  input  logic       dclk,
  input  logic       rst,
  input  logic       i_lmfc,
  input  logic       i_sysref_done,
  input  logic       i_kchar_det,
  input  logic       i_ilas_start,
  input  logic       i_ilas_end,
  input  logic       i_err,
  output logic       o_sync_n,
  output logic       o_buf_release,
  output logic       o_link_up,
  output logic [2:0] o_state
);

  localparam int unsigned KW = $clog2(CGS_K_CNT + 1);
  localparam int unsigned MW = $clog2(ILAS_MF + 1);
  localparam int unsigned TW = $clog2(ILAS_TIMEOUT + 1);
  localparam int unsigned EW = $clog2(ERR_CNT_MAX + 1);

  localparam logic [KW-1:0] KMax   = KW'(CGS_K_CNT);
  localparam logic [MW-1:0] MfMax  = MW'(ILAS_MF);
  localparam logic [TW-1:0] ToMax  = TW'(ILAS_TIMEOUT);
  localparam logic [EW-1:0] ErrSat = EW'(ERR_CNT_MAX);
  localparam logic [EW-1:0] ErrThr = EW'(ERR_THRESH);

  link_state_e   state_q, state_d;
  logic [KW-1:0] k_cnt_q, k_cnt_d;
  logic [MW-1:0] mf_cnt_q, mf_cnt_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [EW-1:0] err_cnt_q, err_cnt_d, err_inc;
  logic          started_q, started_d;   // /R/ seen in this ILAS attempt
  logic          armed_q, armed_d;       // waiting for the release LMFC edge
  logic          sync_n_q, sync_n_d;
  logic          buf_release_q, buf_release_d;
  logic          link_up_q, link_up_d;
  logic          resync;
  logic          lmfc_edge;
  logic          rbd_release;

  jesd204b_lmfc_edge_det #(
    .RBD_DLY (RBD_DLY)
  ) u_edge_det (
    .dclk      (dclk),
    .rst       (rst),
    .i_lmfc    (i_lmfc),
    .i_arm     (armed_q),
    .i_clear   (resync),
    .o_edge    (lmfc_edge),
    .o_release (rbd_release)
  );

  // Next-state and counter logic; resync overrides everything and clears counters
  always_comb begin
    state_d   = state_q;
    k_cnt_d   = k_cnt_q;
    mf_cnt_d  = mf_cnt_q;
    to_cnt_d  = to_cnt_q;
    err_cnt_d = err_cnt_q;
    started_d = started_q;
    armed_d   = armed_q;
    resync    = 1'b0;
    err_inc   = (err_cnt_q == ErrSat) ? err_cnt_q : err_cnt_q + EW'(1);

    unique case (state_q)
      StWaitSysref: begin
        if (i_sysref_done) resync = 1'b1;
      end
      StCgs: begin
        if (i_kchar_det && !i_err) begin
          k_cnt_d = (k_cnt_q == KMax) ? k_cnt_q : k_cnt_q + KW'(1);
        end else begin
          k_cnt_d = '0;
        end
        if (k_cnt_d == KMax) state_d = StSyncRel;
      end
      StSyncRel: begin
        if (!i_kchar_det || i_err) begin
          resync = 1'b1;
        end else if (lmfc_edge) begin
          state_d  = StIlas;
          to_cnt_d = '0;
        end
      end
      StIlas: begin
        // Errors are counted before /A/ so a threshold hit wins
        if (i_err) err_cnt_d = err_inc;
        if (i_err && (err_inc >= ErrThr)) begin
          resync = 1'b1;
        end else if (!started_q) begin
          if (i_ilas_start) begin
            started_d = 1'b1;
          end else if (lmfc_edge) begin
            to_cnt_d = (to_cnt_q == ToMax) ? to_cnt_q : to_cnt_q + TW'(1);
            if (to_cnt_d == ToMax) resync = 1'b1;
          end
        end else if (i_ilas_end) begin
          mf_cnt_d = (mf_cnt_q == MfMax) ? mf_cnt_q : mf_cnt_q + MW'(1);
          if (mf_cnt_d == MfMax) begin
            state_d = StData;
            armed_d = 1'b1;   // registered, so an edge in this same cycle is skipped
          end
        end
      end
      StData: begin
        if (i_err) err_cnt_d = err_inc;
        if (i_err && (err_inc >= ErrThr)) begin
          resync = 1'b1;
        end else if (armed_q && lmfc_edge) begin
          armed_d = 1'b0;
        end
      end
      default: state_d = StWaitSysref;
    endcase

    if (resync) begin
      state_d   = StCgs;
      k_cnt_d   = '0;
      mf_cnt_d  = '0;
      to_cnt_d  = '0;
      err_cnt_d = '0;
      started_d = 1'b0;
      armed_d   = 1'b0;
    end
  end

  // Registered outputs follow the next state
  always_comb begin
    sync_n_d      = (state_d == StIlas) || (state_d == StData);
    link_up_d     = (state_d == StData);
    buf_release_d = (state_d == StData) && (buf_release_q || rbd_release);
  end

  // State, counters and output registers
  always_ff @(posedge dclk or posedge rst) begin
    if (rst) begin
      state_q       <= StWaitSysref;
      k_cnt_q       <= '0;
      mf_cnt_q      <= '0;
      to_cnt_q      <= '0;
      err_cnt_q     <= '0;
      started_q     <= 1'b0;
      armed_q       <= 1'b0;
      sync_n_q      <= 1'b0;
      buf_release_q <= 1'b0;
      link_up_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      k_cnt_q       <= k_cnt_d;
      mf_cnt_q      <= mf_cnt_d;
      to_cnt_q      <= to_cnt_d;
      err_cnt_q     <= err_cnt_d;
      started_q     <= started_d;
      armed_q       <= armed_d;
      sync_n_q      <= sync_n_d;
      buf_release_q <= buf_release_d;
      link_up_q     <= link_up_d;
    end
  end

  assign o_sync_n      = sync_n_q;
  assign o_buf_release = buf_release_q;
  assign o_link_up     = link_up_q;
  assign o_state       = state_q;

endmodule
